// File: rtl/stopwatch_pkg.sv
// Shared mode/select encodings and the mode decision for the stopwatch controller.
package stopwatch_pkg;

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_PAUSE = 2'd1;
  localparam logic [1:0] MODE_ADJ   = 2'd2;

  localparam logic SEL_MIN = 1'b0;
  localparam logic SEL_SEC = 1'b1;

  // Adjust overrides pause; a pause toggled during adjust shows up on exit.
  function automatic logic [1:0] next_mode(input logic adj, input logic paused);
    if (adj)         return MODE_ADJ;
    else if (paused) return MODE_PAUSE;
    else             return MODE_RUN;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a restart-on-bounce debouncer for one raw input.
module sw_debounce #(
  parameter int unsigned         DB_W      = 16,
  parameter logic [DB_W-1:0]     DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db
);

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any return to the current debounced value restarts the stability count.
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == DB_CYCLES - DB_W'(1)) begin
        cnt <= '0;
        db  <= sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// RUN/PAUSE/ADJUST mode controller: conditions panel inputs and issues counter and blanking commands.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned     DB_W      = 16,
  parameter logic [DB_W-1:0] DB_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_btn,
  input  logic       pause_btn,
  input  logic       adj_sw,
  input  logic       sel_sw,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       tick_blink,
  output logic       count_en,
  output logic       inc_min,
  output logic       inc_sec,
  output logic       clear,
  output logic       blank_min,
  output logic       blank_sec,
  output logic [1:0] mode
);

  logic       clr_db, pause_db, adj_db, sel_db;
  logic       clr_q, pause_q;
  logic       clr_edge, pause_edge;
  logic       paused;
  logic       blink;
  logic [1:0] state;
  logic       is_adj, is_pause, is_run;

  sw_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .reset_n(reset_n), .raw(clr_btn), .db(clr_db)
  );
  sw_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk(clk), .reset_n(reset_n), .raw(pause_btn), .db(pause_db)
  );
  sw_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_adj (
    .clk(clk), .reset_n(reset_n), .raw(adj_sw), .db(adj_db)
  );
  sw_debounce #(.DB_W(DB_W), .DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk(clk), .reset_n(reset_n), .raw(sel_sw), .db(sel_db)
  );

  assign clr_edge   = clr_db & ~clr_q;
  assign pause_edge = pause_db & ~pause_q;

  // The unused encoding falls through to RUN.
  assign is_adj   = (state == MODE_ADJ);
  assign is_pause = (state == MODE_PAUSE);
  assign is_run   = ~is_adj & ~is_pause;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_q    <= 1'b0;
      pause_q  <= 1'b0;
      paused   <= 1'b0;
      blink    <= 1'b0;
      state    <= MODE_RUN;
      count_en <= 1'b0;
      inc_min  <= 1'b0;
      inc_sec  <= 1'b0;
      clear    <= 1'b0;
    end else begin
      clr_q   <= clr_db;
      pause_q <= pause_db;

      if (clr_edge)        paused <= 1'b0;
      else if (pause_edge) paused <= ~paused;

      state <= next_mode(adj_db, paused);

      // Held low outside adjust, so every adjust entry starts with digits shown.
      if (!is_adj)         blink <= 1'b0;
      else if (tick_blink) blink <= ~blink;

      count_en <= is_run & tick_1hz & ~clr_edge;
      inc_min  <= is_adj & tick_2hz & (sel_db == SEL_MIN) & ~clr_edge;
      inc_sec  <= is_adj & tick_2hz & (sel_db == SEL_SEC) & ~clr_edge;
      clear    <= clr_edge;
    end
  end

  assign blank_min = is_adj & (sel_db == SEL_MIN) & blink;
  assign blank_sec = is_adj & (sel_db == SEL_SEC) & blink;
  assign mode      = is_adj ? MODE_ADJ : (is_pause ? MODE_PAUSE : MODE_RUN);

endmodule
